// File: rtl/serial_byte_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_byte_loader_pkg
// Description : Shared types and helpers for the serial byte loader and the
//               8-bit storage register stage it feeds.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_byte_loader_pkg;

    // Default frame width; the register stage is built with the same value.
    localparam int C_DATA_W = 8;

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    // Even-parity bit for up to 32 data bits (unused upper bits must be zero).
    function automatic logic f_even_parity(input logic [31:0] i_data);
        return ^i_data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_byte_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_byte_loader_if
// Description : Serial input and register-write output bundle of the loader.
//               master = stimulus / upstream side, slave = the loader itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_byte_loader_if #(
    parameter int DATA_W = 8
) ();

    logic              frame_start;
    logic              bit_valid;
    logic              bit_in;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              parity_err;
    logic [7:0]        byte_count;

    modport master (
        output frame_start,
        output bit_valid,
        output bit_in,
        input  wr,
        input  wdata,
        input  busy,
        input  parity_err,
        input  byte_count
    );

    modport slave (
        input  frame_start,
        input  bit_valid,
        input  bit_in,
        output wr,
        output wdata,
        output busy,
        output parity_err,
        output byte_count
    );

endinterface
`default_nettype wire

// File: rtl/serial_byte_loader_shift.sv
`default_nettype none
// ============================================================================
// Module      : serial_shift_unit
// Description : Shift register and bit counter for one serial frame.
//               o_done flags that the current shift is the last data bit;
//               o_data_next is the register value after the current shift.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_shift_unit #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_clear,
    input  wire logic              i_shift_en,
    input  wire logic              i_bit,
    output logic [DATA_W-1:0]      o_data,
    output logic [DATA_W-1:0]      o_data_next,
    output logic                   o_done
);

    localparam int C_CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]  r_data;
    logic [C_CNT_W-1:0] r_count;
    logic [DATA_W-1:0]  w_shifted;
    logic               w_last;

    // Shift direction: first bit ends up in the MSB or in the LSB.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_data[DATA_W-2:0], i_bit};
        end else begin : g_lsb_first
            assign w_shifted = {i_bit, r_data[DATA_W-1:1]};
        end
    endgenerate

    assign w_last = (r_count == C_CNT_W'(DATA_W - 1));

    // Clear discards partial bits; the counter wraps to zero after the last bit.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_shift_en) begin
            r_data  <= w_shifted;
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    assign o_data      = r_data;
    assign o_data_next = w_shifted;
    assign o_done      = i_shift_en && w_last;

endmodule
`default_nettype wire

// File: rtl/serial_byte_loader.sv
`default_nettype none
// ============================================================================
// Module      : serial_byte_loader
// Description : Assembles a serial frame (optionally even-parity protected)
//               into a byte and issues one single-cycle write strobe per
//               good frame. Counts accepted bytes modulo 256.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_byte_loader
    import serial_byte_loader_pkg::*;
#(
    parameter int DATA_W    = C_DATA_W,
    parameter int PARITY_EN = 1,
    parameter int MSB_FIRST = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    serial_byte_loader_if.slave bus
);

    state_t            r_state;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_busy;
    logic              r_parity_err;
    logic [7:0]        r_byte_count;

    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_data_next;
    logic              w_done;
    logic              w_shift_en;
    logic              w_parity_ok;

    // frame_start has priority: a bit presented with it is never sampled.
    assign w_shift_en  = (r_state == ST_SHIFT) && bus.bit_valid && !bus.frame_start;
    assign w_parity_ok = (bus.bit_in == f_even_parity(32'(w_data)));

    serial_shift_unit #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (bus.frame_start),
        .i_shift_en  (w_shift_en),
        .i_bit       (bus.bit_in),
        .o_data      (w_data),
        .o_data_next (w_data_next),
        .o_done      (w_done)
    );

    // Frame FSM with registered strobe, data, status and byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wr         <= 1'b0;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_parity_err <= 1'b0;
            r_byte_count <= 8'd0;
        end else begin
            r_wr         <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // A frame_start here just restarts the count (done in the shift unit).
                    if (!bus.frame_start && w_done) begin
                        if (PARITY_EN != 0) begin
                            r_state <= ST_PARITY;
                        end else begin
                            // Last bit is still in flight, so capture the post-shift value.
                            r_state <= ST_WRITE;
                            r_wr    <= 1'b1;
                            r_wdata <= w_data_next;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bus.frame_start) begin
                        r_state <= ST_SHIFT;
                    end else if (bus.bit_valid) begin
                        if (w_parity_ok) begin
                            r_state <= ST_WRITE;
                            r_wr    <= 1'b1;
                            r_wdata <= w_data;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                            r_parity_err <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_byte_count <= r_byte_count + 8'd1;
                    if (bus.frame_start) begin
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr         = r_wr;
    assign bus.wdata      = r_wdata;
    assign bus.busy       = r_busy;
    assign bus.parity_err = r_parity_err;
    assign bus.byte_count = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_serial_byte_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_byte_loader
// Description : Directed self-checking bench for serial_byte_loader
//               (DATA_W=8, PARITY_EN=1, MSB_FIRST=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_byte_loader;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;
    int wr_cnt;
    logic prev_wr;

    serial_byte_loader_if #(.DATA_W(8)) bus ();

    serial_byte_loader #(
        .DATA_W    (8),
        .PARITY_EN (1),
        .MSB_FIRST (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Count strobes and flag any strobe lasting two cycles.
    always @(negedge clk) begin
        if (bus.wr === 1'b1) wr_cnt++;
        if (prev_wr === 1'b1) check("wr_not_adjacent", {31'd0, bus.wr}, 32'd0);
        prev_wr = bus.wr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        step();
        bus.bit_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            step();
            check("busy_in_gap", {31'd0, bus.busy}, 32'd1);
        end
    endtask

    // frame_start, 8 data bits MSB first, then parity; returns after the parity edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input int gap);
        pulse_start();
        for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
        send_bit(p, 0);
    endtask

    int wr_base;
    logic [7:0] fd;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wr_cnt   = 0;
        prev_wr  = 1'b0;
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.bit_in      = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset applied mid-frame
        pulse_start();
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        check("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        step(); step(); step();
        check("rst_wr", {31'd0, bus.wr}, 32'd0);
        check("rst_wdata", {24'd0, bus.wdata}, 32'h00);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
        check("rst_byte_count", {24'd0, bus.byte_count}, 32'd0);
        rst = 1'b0;
        wr_base = wr_cnt;
        repeat (6) step();
        check("idle_no_wr", wr_cnt, wr_base);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        // bit_valid with no frame_start is ignored
        send_bit(1'b1, 0);
        check("stray_bit_busy", {31'd0, bus.busy}, 32'd0);

        // Good frame 0xA5, parity 0
        wr_base = wr_cnt;
        send_frame(8'hA5, 1'b0, 0);
        check("good_wr", {31'd0, bus.wr}, 32'd1);
        check("good_wdata", {24'd0, bus.wdata}, 32'hA5);
        check("good_count_pre", {24'd0, bus.byte_count}, 32'd0);
        step();
        check("good_wr_low", {31'd0, bus.wr}, 32'd0);
        check("good_count", {24'd0, bus.byte_count}, 32'd1);
        check("good_busy_end", {31'd0, bus.busy}, 32'd0);
        check("good_wr_pulses", wr_cnt - wr_base, 32'd1);

        // Bad parity: 0x07 needs parity 1, send 0
        wr_base = wr_cnt;
        send_frame(8'h07, 1'b0, 0);
        check("bad_perr", {31'd0, bus.parity_err}, 32'd1);
        check("bad_wr", {31'd0, bus.wr}, 32'd0);
        step();
        check("bad_perr_low", {31'd0, bus.parity_err}, 32'd0);
        check("bad_wdata_held", {24'd0, bus.wdata}, 32'hA5);
        check("bad_count", {24'd0, bus.byte_count}, 32'd1);
        check("bad_busy", {31'd0, bus.busy}, 32'd0);
        step();
        check("bad_no_wr", wr_cnt - wr_base, 32'd0);

        // Resync: 4 partial bits then a full 0x3C frame
        wr_base = wr_cnt;
        pulse_start();
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_frame(8'h3C, 1'b0, 0);
        check("resync_wr", {31'd0, bus.wr}, 32'd1);
        check("resync_wdata", {24'd0, bus.wdata}, 32'h3C);
        step();
        check("resync_count", {24'd0, bus.byte_count}, 32'd2);
        check("resync_pulses", wr_cnt - wr_base, 32'd1);

        // frame_start together with bit_valid: bit not sampled
        wr_base = wr_cnt;
        bus.frame_start = 1'b1;
        bus.bit_valid   = 1'b1;
        bus.bit_in      = 1'b0;
        step();
        bus.frame_start = 1'b0;
        bus.bit_valid   = 1'b0;
        fd = 8'hC3;
        for (int i = 7; i >= 0; i--) send_bit(fd[i], 0);
        send_bit(1'b0, 0);
        check("tie_wr", {31'd0, bus.wr}, 32'd1);
        check("tie_wdata", {24'd0, bus.wdata}, 32'hC3);
        step();
        check("tie_count", {24'd0, bus.byte_count}, 32'd3);

        // Gapped bits: 0xFF with two idle cycles between bits
        wr_base = wr_cnt;
        send_frame(8'hFF, 1'b0, 2);
        check("gap_wr", {31'd0, bus.wr}, 32'd1);
        check("gap_wdata", {24'd0, bus.wdata}, 32'hFF);
        step();
        check("gap_count", {24'd0, bus.byte_count}, 32'd4);
        check("gap_pulses", wr_cnt - wr_base, 32'd1);

        // 256 back-to-back frames from a fresh count, frame_start in each WRITE
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("wrap_rst_count", {24'd0, bus.byte_count}, 32'd0);
        wr_base = wr_cnt;
        pulse_start();
        for (int k = 0; k < 256; k++) begin
            fd = 8'(k * 37 + 11);
            for (int i = 7; i >= 0; i--) send_bit(fd[i], 0);
            send_bit(^fd, 0);
            check("b2b_wr", {31'd0, bus.wr}, 32'd1);
            check("b2b_wdata", {24'd0, bus.wdata}, {24'd0, fd});
            if (k < 255) begin
                bus.frame_start = 1'b1;
                step();
                bus.frame_start = 1'b0;
                check("b2b_count", {24'd0, bus.byte_count}, 32'(k + 1));
                check("b2b_busy", {31'd0, bus.busy}, 32'd1);
            end else begin
                step();
                check("wrap_count", {24'd0, bus.byte_count}, 32'd0);
                check("wrap_busy", {31'd0, bus.busy}, 32'd0);
            end
        end
        step();
        check("wrap_pulses", wr_cnt - wr_base, 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_byte_loader.md
Name: serial_byte_loader

Overview:
- Upstream feeder for the 8-bit storage register stage.
- Assembles a serially delivered byte, with an optional even-parity bit, into a parallel word.
- On each good byte, issues exactly one single-cycle write strobe (wr) with wdata; this pair drives the register's wr/wdata inputs directly.
- Rejects corrupted frames and counts accepted bytes.

Parameters:
- DATA_W, 8: bits per frame; equals register width.
- PARITY_EN, 1: 1 = one even-parity bit follows the data bits; 0 = no parity phase.
- MSB_FIRST, 1: 1 = first received bit lands in wdata[DATA_W-1]; 0 = first bit lands in wdata[0].

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- frame_start  input  1  one-cycle pulse marking the start of a frame; carries no data bit.
- bit_valid  input  1  bit_in is sampled on cycles where this is 1.
- bit_in  input  1  serial data or parity bit.
- wr  output  1  one-cycle write strobe to the register stage.
- wdata  output  DATA_W  assembled byte; registered, held between writes.
- busy  output  1  1 whenever state != IDLE.
- parity_err  output  1  one-cycle pulse on parity mismatch.
- byte_count  output  8  count of accepted (written) bytes; wraps 255 -> 0.

Behaviour:
- Reset: rst=1 at a clock edge forces the following, regardless of state (including mid-frame):
  - state = IDLE, bit counter = 0, shift register = 0.
  - wr = 0, wdata = 0, busy = 0, parity_err = 0, byte_count = 0.
- States: IDLE, SHIFT, PARITY, WRITE.
- IDLE:
  - frame_start=1 -> SHIFT, bit counter cleared.
  - bit_valid without a preceding frame_start is ignored.
- SHIFT:
  - Each cycle with bit_valid=1 shifts bit_in in (direction per MSB_FIRST) and increments the counter.
  - After the DATA_W-th bit: -> PARITY if PARITY_EN=1, else -> WRITE.
  - Cycles with bit_valid=0 hold all state; there is no timeout.
- PARITY:
  - On bit_valid=1, compare bit_in against the XOR of the shifted data bits.
  - Match -> WRITE.
  - Mismatch -> parity_err=1 for exactly one cycle, -> IDLE. No wr, wdata unchanged, byte_count unchanged.
- WRITE (one cycle):
  - wr=1; wdata updated to the shift-register contents on the same edge that enters WRITE, so wdata is stable while wr is high.
  - byte_count increments as WRITE exits (visible the next cycle). -> IDLE.
- Latency: wr is high in the cycle immediately after the edge that sampled the final bit (last data bit, or the parity bit when PARITY_EN=1).
- wr is never high for two consecutive cycles. The downstream register gates rdata to 0 while wr=1, so a stretched strobe is a defect.
- frame_start during SHIFT or PARITY: abort the current frame and resynchronise.
  - Counter cleared, stay in or return to SHIFT.
  - No wr, no parity_err. Partial bits are discarded.
- frame_start during WRITE: the write completes normally; next state is SHIFT instead of IDLE.
- frame_start and bit_valid in the same cycle: frame_start wins; bit_in is not sampled.
- byte_count wraps modulo 256 silently.

Decomposition:
- Shared package:
  - State enum (IDLE, SHIFT, PARITY, WRITE).
  - Default DATA_W constant, shared with the register stage.
  - Even-parity function (XOR reduction).
- One natural sub-module: serial_shift_unit, containing the shift register, bit counter and done flag, parameterised by DATA_W and MSB_FIRST.
- FSM, strobe generation and byte counter stay in the top.

Test Plan:
- Reset: hold rst 3 cycles mid-frame -> wr=0, wdata=0x00, busy=0, byte_count=0; no wr for at least 5 cycles after release without stimulus.
- Good frame (PARITY_EN=1, MSB_FIRST=1): frame_start, bits 1,0,1,0,0,1,0,1, parity 0 -> exactly one wr pulse with wdata=0xA5, one cycle after the parity bit; byte_count=1 on the following cycle.
- Bad parity: frame_start, bits for 0x07, parity 0 (correct value is 1) -> parity_err pulses once, no wr, wdata holds 0xA5, byte_count unchanged.
- Resync: frame_start, 4 bits, frame_start, full frame 0x3C with parity 0 -> single wr with wdata=0x3C; no strobe for the aborted partial frame.
- Gapped bits: 0xFF with parity 0, bit_valid low 2 cycles between each bit -> single wr with wdata=0xFF; busy stays high throughout the frame.
- Wrap and back-to-back: 256 good frames, with frame_start asserted in each WRITE cycle -> 256 wr pulses, never two adjacent; byte_count returns to 0.
